// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioning path: channel FSM
// encoding and the clock/debounce constants also used by the timer core.
package key_conditioner_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DB_MS             = 20;
  localparam int DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DB_MS;

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_ARM_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_ARM_UP = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with a saturating
// stability counter, and registered level / press / release outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_UP     | key released and accepted; waiting for a sampled 1
// ST_ARM_DN | sampled 1, counting stable samples before accepting press
// ST_DOWN   | key pressed and accepted; waiting for a sampled 0
// ST_ARM_UP | sampled 0, counting stable samples before accepting release
module key_debounce_ch
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_UP;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= i_key_raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Strobes default low so each one lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_UP: begin
        if (r_s2) begin
          w_state_nxt = ST_ARM_DN;
          w_cnt_nxt   = '0;
        end
      end
      ST_ARM_DN: begin
        if (!r_s2) begin
          w_state_nxt = ST_UP;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DOWN;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DOWN: begin
        if (!r_s2) begin
          w_state_nxt = ST_ARM_UP;
          w_cnt_nxt   = '0;
        end
      end
      ST_ARM_UP: begin
        if (r_s2) begin
          w_state_nxt = ST_DOWN;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_UP;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_UP;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button conditioner: N_KEYS independent debounced channels
// feeding clean level and strobe vectors to the reaction-timer core.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS    = 3,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic              clk_50M,
  input  logic              clear,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_rise,
  output logic [N_KEYS-1:0] key_fall
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .i_clk    (clk_50M),
      .i_rst    (clear),
      .i_key_raw(key_raw[g]),
      .o_level  (key_level[g]),
      .o_rise   (key_rise[g]),
      .o_fall   (key_fall[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a short debounce window (4 cycles).
module tb_key_conditioner;

  localparam int N_KEYS = 3;
  localparam int DB     = 4;

  logic              clk_50M;
  logic              clear;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_rise;
  logic [N_KEYS-1:0] key_fall;

  int checks;
  int errors;

  key_conditioner #(
    .N_KEYS   (N_KEYS),
    .DB_CYCLES(DB)
  ) dut (
    .clk_50M  (clk_50M),
    .clear    (clear),
    .key_raw  (key_raw),
    .key_level(key_level),
    .key_rise (key_rise),
    .key_fall (key_fall)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  // Leaves clear deasserted mid-cycle; the next rising edge is edge 1.
  task automatic do_reset();
    clear   = 1'b1;
    key_raw = '0;
    repeat (2) @(posedge clk_50M);
    #5;
    clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic test_reset();
    clear   = 1'b1;
    key_raw = '0;
    #1;
    checks++;
    if (key_level !== 3'b000 || key_rise !== 3'b000 || key_fall !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got level=%b rise=%b fall=%b expected all 000",
               key_level, key_rise, key_fall);
    end
    do_reset();
    checks++;
    if (key_level !== 3'b000 || key_rise !== 3'b000 || key_fall !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got level=%b rise=%b fall=%b expected all 000",
               key_level, key_rise, key_fall);
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp_rise, exp_level;
    do_reset();
    key_raw = 3'b010;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_rise  = (n == 7) ? 3'b010 : 3'b000;
      exp_level = (n >= 7) ? 3'b010 : 3'b000;
      checks++;
      if (key_rise !== exp_rise || key_level !== exp_level || key_fall !== 3'b000) begin
        errors++;
        $display("FAIL clean_press edge %0d: got rise=%b level=%b fall=%b expected rise=%b level=%b fall=000",
                 n, key_rise, key_level, key_fall, exp_rise, exp_level);
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    do_reset();
    key_raw = 3'b001;
    rises   = 0;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 4) key_raw = 3'b000;
      if (key_rise !== 3'b000) rises++;
      checks++;
      if (key_level !== 3'b000) begin
        errors++;
        $display("FAIL glitch4_level edge %0d: got %b expected 000", n, key_level);
      end
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL glitch4_rises: got %0d expected 0", rises);
    end

    do_reset();
    key_raw = 3'b001;
    rises   = 0;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 5) key_raw = 3'b000;
      if (key_rise !== 3'b000) rises++;
      if (n == 7) begin
        checks++;
        if (key_rise !== 3'b001 || key_level !== 3'b001) begin
          errors++;
          $display("FAIL glitch5_accept edge 7: got rise=%b level=%b expected rise=001 level=001",
                   key_rise, key_level);
        end
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL glitch5_rises: got %0d expected 1", rises);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int rises, falls;
    pat   = 6'b101101;  // bit 0 drives edge 1: 1,0,1,1,0,1
    rises = 0;
    falls = 0;
    do_reset();
    key_raw = {2'b00, pat[0]};
    for (int n = 1; n <= 20; n++) begin
      step();
      key_raw = (n < 6) ? {2'b00, pat[n]} : 3'b001;
      if (key_rise !== 3'b000) rises++;
      if (key_fall !== 3'b000) falls++;
      if (n == 12) begin
        checks++;
        if (key_rise !== 3'b001) begin
          errors++;
          $display("FAIL bounce_rise edge 12: got %b expected 001", key_rise);
        end
      end
    end
    checks++;
    if (rises != 1 || falls != 0) begin
      errors++;
      $display("FAIL bounce_counts: got rises=%0d falls=%0d expected rises=1 falls=0", rises, falls);
    end
  endtask

  task automatic test_release();
    logic [2:0] exp_fall, exp_level;
    do_reset();
    key_raw = 3'b100;
    repeat (10) step();
    checks++;
    if (key_level !== 3'b100) begin
      errors++;
      $display("FAIL release_pressed: got level=%b expected 100", key_level);
    end
    key_raw = 3'b000;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp_fall  = (n == 7) ? 3'b100 : 3'b000;
      exp_level = (n < 7)  ? 3'b100 : 3'b000;
      checks++;
      if (key_fall !== exp_fall || key_level !== exp_level || key_rise !== 3'b000) begin
        errors++;
        $display("FAIL release edge %0d: got fall=%b level=%b rise=%b expected fall=%b level=%b rise=000",
                 n, key_fall, key_level, key_rise, exp_fall, exp_level);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_rise;
    do_reset();
    key_raw = 3'b101;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp_rise = (n == 7) ? 3'b101 : 3'b000;
      checks++;
      if (key_rise !== exp_rise) begin
        errors++;
        $display("FAIL simultaneous edge %0d: got rise=%b expected %b", n, key_rise, exp_rise);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_rise, exp_level;
    do_reset();
    key_raw = 3'b010;
    repeat (10) step();
    checks++;
    if (key_level !== 3'b010) begin
      errors++;
      $display("FAIL midrst_pressed: got level=%b expected 010", key_level);
    end
    key_raw = 3'b011;
    repeat (5) step();
    clear = 1'b1;
    #2;
    checks++;
    if (key_level !== 3'b000 || key_rise !== 3'b000 || key_fall !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async: got level=%b rise=%b fall=%b expected all 000",
               key_level, key_rise, key_fall);
    end
    repeat (2) @(posedge clk_50M);
    #5;
    clear = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp_rise  = (n == 7) ? 3'b011 : 3'b000;
      exp_level = (n >= 7) ? 3'b011 : 3'b000;
      checks++;
      if (key_rise !== exp_rise || key_level !== exp_level) begin
        errors++;
        $display("FAIL midrst_held edge %0d: got rise=%b level=%b expected rise=%b level=%b",
                 n, key_rise, key_level, exp_rise, exp_level);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clear   = 1'b1;
    key_raw = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-conditioning stage for the reaction-timer top level.
- Takes the raw, asynchronous, bouncing push-button lines (clear-request, start and stop) from the board and delivers clean, clock-synchronous signals to the timer FSM.
- Per key, it produces a debounced level plus one-cycle press and release strobes.
- Sits directly between the board pins and the game/timer core. All logic runs on the 50 MHz clock.

Parameters:
- N_KEYS, 3, number of independent button channels.
- DB_CYCLES, 1000000, stable-sample count required to accept an edge (20 ms at 50 MHz). Must be ≥1; benches override it with a small value.
- CNT_W, $clog2(DB_CYCLES+1), debounce counter width (derived; not overridden).

Ports:
- clk_50M  in  1  system clock, 50 MHz; all state updates on the rising edge.
- clear  in  1  reset; asynchronous, active-high.
- key_raw  in  N_KEYS  raw button inputs, active-high, asynchronous, may bounce.
- key_level  out  N_KEYS  debounced key state, 1 = pressed.
- key_rise  out  N_KEYS  one-cycle strobe on accepted press.
- key_fall  out  N_KEYS  one-cycle strobe on accepted release.

Behaviour:
- Reset: clear=1 asynchronously forces all outputs to 0, synchronizer flops to 0, every channel FSM to UP and counters to 0. This applies at any time, including mid-debounce.
- Synchronizer: two flops per key, s1<=key_raw, s2<=s1. The FSM observes s2, so the FSM sees key_raw delayed 2 edges. No combinational path exists from key_raw to any output.
- Per-channel FSM states and transitions (cnt is CNT_W bits):
  - UP: key_level=0. If s2=1, go to ARM_DN with cnt<=0.
  - ARM_DN: if s2=0, return to UP (press rejected, no strobe). Else if cnt==DB_CYCLES-1, go to DOWN and assert key_level<=1 and key_rise<=1 on the same edge. Else cnt<=cnt+1.
  - DOWN: key_level=1. If s2=0, go to ARM_UP with cnt<=0.
  - ARM_UP: if s2=1, return to DOWN (no strobe). Else if cnt==DB_CYCLES-1, go to UP and assert key_level<=0 and key_fall<=1. Else cnt<=cnt+1.
- Strobes: key_rise/key_fall are registered and high for exactly one clock, then cleared. A single key never raises rise and fall in the same cycle.
- Latency: with key_raw stable high from edge E (first sampling edge), key_level and key_rise assert at edge E+DB_CYCLES+2, i.e. on the (DB_CYCLES+3)-th edge counting E as 1. Release is symmetric.
- Acceptance criterion: an edge is accepted iff key_raw is sampled at the new value on DB_CYCLES+1 consecutive edges. Any shorter pulse or bounce produces no output change.
- Counter saturation: cnt never exceeds DB_CYCLES-1; there is no wrap-around.
- Channel independence: channels are fully independent. Simultaneous presses on several keys yield strobes in the same cycle when their timing is identical.
- Held through reset: a key held while clear deasserts is treated as a fresh press. key_rise fires DB_CYCLES+3 edges after clear drops, assuming the key remains held.
- Reset deassertion: takes effect on the first rising clk_50M edge after clear falls.

Decomposition:
- Shared package: FSM state encoding (UP=2'd0, ARM_DN=2'd1, DOWN=2'd2, ARM_UP=2'd3) and the 20 ms / 50 MHz default constant. The reaction-timer core reuses the clock constant.
- Sub-module key_debounce_ch: one synchronizer, FSM and counter per key. key_conditioner instantiates N_KEYS copies in a generate loop and concatenates their outputs.

Test Plan (DB_CYCLES=4, clock period 20 ns):
- Clean press: key_raw[1] 0->1 at edge 1, held for 20 cycles -> key_rise[1] is high only in the cycle after edge 7; key_level[1]=1 from edge 7 onward; other bits stay 0.
- Glitch: key_raw[0] high for exactly 4 edges, then 0 -> no key_rise and key_level stays 0. Repeating with 5 edges -> key_rise fires once.
- Bounce: press pattern 1,0,1,1,0,1 then steady 1 -> exactly one key_rise, 7 edges after the last 0->1 transition; no key_fall.
- Release: from DOWN, drop key_raw[2] and hold it low -> key_fall[2] is a single pulse at edge 7 of the low period, and key_level[2] returns to 0 on the same edge.
- Simultaneous: key_raw[0] and key_raw[2] rise on the same edge -> key_rise=3'b101 in one cycle.
- Reset mid-operation: assert clear during ARM_DN (edge 5 of a press) -> all outputs 0 immediately without waiting for a clock. After clear drops with the key still held, key_rise fires on the 7th edge.
